// File: rtl/btn_conditioner.sv
// rtl/btn_conditioner.sv - N-channel push-button synchroniser, debouncer, edge strobes and auto-repeat
//
// Purpose: one instance conditions every board button. Each channel is fully
// independent: synchroniser chain, debounce counter, repeat timer and FSM.
//
// Ports:
//   clk_100MHz   in   1      system clock
//   reset        in   1      synchronous, active-high reset
//   btn_in       in   N_BTN  raw asynchronous button levels, active-high
//   repeat_en    in   N_BTN  per-channel auto-repeat enable
//   btn_level    out  N_BTN  debounced level
//   btn_press    out  N_BTN  one-cycle strobe on debounced 0->1
//   btn_release  out  N_BTN  one-cycle strobe on debounced 1->0
//   btn_step     out  N_BTN  one-cycle strobe on press and on each auto-repeat

module btn_conditioner #(
    parameter int N_BTN           = 5,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REPEAT_DELAY    = 50_000_000,
    parameter int REPEAT_RATE     = 10_000_000
) (
    input  logic             clk_100MHz,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_in,
    input  logic [N_BTN-1:0] repeat_en,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_step
);

    localparam int DW    = $clog2(DEBOUNCE_CYCLES);
    localparam int R_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW    = $clog2(R_MAX);

    localparam logic [DW-1:0] D_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RR_LAST = RW'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {
        R_IDLE,
        R_DELAY,
        R_REPEAT
    } rstate_t;

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_sr;
        logic                   sync;
        logic                   stable;
        logic [DW-1:0]          dcnt;
        logic                   press_r;
        logic                   release_r;
        logic                   step_r;
        logic [RW-1:0]          rcnt;
        rstate_t                state;

        logic accept;
        logic press_evt;
        logic rel_evt;

        assign sync = sync_sr[SYNC_STAGES-1];

        // The new level is accepted on the edge that sees the final count while
        // the synchronised input still differs; stable and the strobes update
        // together so press/release coincide with the first new btn_level cycle.
        assign accept    = (sync != stable) && (dcnt == D_LAST);
        assign press_evt = accept && sync;
        assign rel_evt   = accept && !sync;

        always_ff @(posedge clk_100MHz) begin
            if (reset) begin
                sync_sr   <= '0;
                stable    <= 1'b0;
                dcnt      <= '0;
                press_r   <= 1'b0;
                release_r <= 1'b0;
            end else begin
                sync_sr   <= {sync_sr[SYNC_STAGES-2:0], btn_in[i]};
                press_r   <= press_evt;
                release_r <= rel_evt;
                if (sync == stable) begin
                    dcnt <= '0;
                end else if (accept) begin
                    stable <= sync;
                    dcnt   <= '0;
                end else begin
                    dcnt <= dcnt + DW'(1);
                end
            end
        end

        // Repeat FSM. Release or a dropped enable wins over timer expiry, so no
        // step is emitted in the exit cycle.
        always_ff @(posedge clk_100MHz) begin
            if (reset) begin
                state  <= R_IDLE;
                rcnt   <= '0;
                step_r <= 1'b0;
            end else begin
                step_r <= 1'b0;
                case (state)
                    R_IDLE: begin
                        if (press_evt) begin
                            step_r <= 1'b1;
                            if (repeat_en[i]) begin
                                state <= R_DELAY;
                                rcnt  <= '0;
                            end
                        end
                    end
                    R_DELAY: begin
                        if (rel_evt || !repeat_en[i]) begin
                            state <= R_IDLE;
                        end else if (rcnt == RD_LAST) begin
                            step_r <= 1'b1;
                            rcnt   <= '0;
                            state  <= R_REPEAT;
                        end else begin
                            rcnt <= rcnt + RW'(1);
                        end
                    end
                    R_REPEAT: begin
                        if (rel_evt || !repeat_en[i]) begin
                            state <= R_IDLE;
                        end else if (rcnt == RR_LAST) begin
                            step_r <= 1'b1;
                            rcnt   <= '0;
                        end else begin
                            rcnt <= rcnt + RW'(1);
                        end
                    end
                    default: begin
                        state <= R_IDLE;
                        rcnt  <= '0;
                    end
                endcase
            end
        end

        assign btn_level[i]   = stable;
        assign btn_press[i]   = press_r;
        assign btn_release[i] = release_r;
        assign btn_step[i]    = step_r;
    end

endmodule
